coeff_bram_writer: RTL and testbench
====================================

// Module: coeff_bram_writer
// PURPOSE
//  Host-side loader for the 2D FIR coefficient BRAM: the write end of the bank the coefficient
//  fetcher reads after each vs_i falling edge. Takes a valid/ready stream of signed 16-bit taps,
//  row-major (c00..c44), and writes them sign-extended to BRAM addresses 0..NUM_COEFF-1.
//  Withholds s_ready while the fetcher is reading, checks frame length, and reports completion.
// PARAMETERS
//  NUM_COEFF     25             taps per set (5x5 kernel)
//  COEFF_W       16             signed tap width on s_data
//  DATA_W        32             BRAM word width; tap sign-extended into it
//  ADDR_W        6              BRAM address width
//  GUARD_CYCLES  NUM_COEFF+2    s_ready hold-off after vs_i falling edge
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous reset, active low
//  s_valid      in   1        host tap valid
//  s_ready      out  1        block accepts tap; transfer = s_valid & s_ready
//  s_data       in   COEFF_W  signed tap
//  s_last       in   1        marks final tap of a set
//  vs_i         in   1        vertical sync; falling edge starts the fetcher's read
//  bram_addr    out  ADDR_W   BRAM write address
//  bram_wdata   out  DATA_W   BRAM write data, {{DATA_W-COEFF_W{s_data[MSB]}}, s_data}
//  bram_we      out  1        BRAM write enable, single-cycle per tap
//  load_done    out  1        1-cycle pulse: complete, correct-length set written
//  load_err     out  1        level: last set was wrong length; cleared by next set's first tap
//  busy         out  1        high in LOAD or DRAIN
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; wr_cnt=0; guard=0; vs_dly=0.
//  Edge: vs_dly<=vs_i; vs_fall = vs_dly & ~vs_i. vs_fall loads guard=GUARD_CYCLES, decremented
//   each cycle to 0; re-triggers on a new edge.
//  s_ready = (state!=DONE) & (guard==0) & ~vs_fall (combinational).
//  Write latency 1: tap accepted at cycle N -> bram_we=1, bram_addr=wr_cnt, bram_wdata at N+1.
//   bram_we is 0 on every other cycle.
//  A tap accepted the cycle before vs_fall is still written at N+1; the fetcher can then latch
//   a mixed set. The host loads during blanking; this block does not prevent it.
//  FSM:
//   IDLE : first accepted tap -> clears load_err, writes addr 0, wr_cnt=1 -> LOAD.
//          Tap with s_last in IDLE (NUM_COEFF>1) -> load_err=1, no write, stay IDLE.
//   LOAD : each tap written at wr_cnt, wr_cnt++.
//          s_last & wr_cnt==NUM_COEFF-1 -> write, -> DONE.
//          s_last & wr_cnt<NUM_COEFF-1 -> write, load_err=1, -> IDLE. Short set; no load_done.
//          ~s_last & wr_cnt==NUM_COEFF-1 -> write, load_err=1, -> DRAIN.
//   DRAIN: taps accepted and discarded (no bram_we) until s_last accepted -> IDLE.
//   DONE : one cycle, s_ready=0. load_done=1 aligned with the final tap's bram_we. -> IDLE, wr_cnt=0.
//  vs_fall freezes acceptance only; state, wr_cnt and load_err are kept.
//   A load resumes at the next address when guard expires.
//  Reset mid-load: returns to IDLE; next set starts at addr 0. Partial BRAM contents remain.
// CONFIGURATION
//  COEFF_SUM_EN defined: extra output coeff_sum [COEFF_W+5-1:0], signed.
//   Running sum of the set's taps, cleared on the first tap of a set.
//   Value is valid and held from the load_done cycle until the next set's first tap (DC-gain check).
//   Reset value 0.
//  COEFF_SUM_EN undefined: no port, no accumulator. All other behaviour identical.
// TESTING
//  1 Taps 0x0001..0x0019, s_last on 25th, vs_i high -> 25 writes, addr 0..24,
//    wdata 0x00000001..0x00000019; load_done once, aligned with addr 24; load_err=0.
//  2 Tap 0xFFF0 at position 0 -> bram_wdata=0xFFFFFFF0 at addr 0.
//  3 vs_i falls after tap 10 accepted -> s_ready low in the edge cycle plus 27 cycles.
//    Resumes at addr 10; no tap lost or duplicated; 25 writes total.
//  4 s_last on 5th tap -> writes addr 0..4, load_err=1, no load_done.
//    Next full set starts at addr 0, load_err clears on its first tap.
//  5 30 taps, s_last on 30th -> writes addr 0..24 only, load_err=1 from tap 25.
//    Taps 26..30 accepted with bram_we=0; then IDLE.
//  6 rst_n low after tap 12 -> outputs 0. Full reload writes addr 0..24, load_done=1.
//    With COEFF_SUM_EN: 25 taps of 0xFFFF -> coeff_sum=-25.

Source files
------------

// File: rtl/coeff_bram_writer_if.sv
// coeff_bram_writer_if: valid/ready tap stream from host to coefficient loader
interface coeff_bram_writer_if #(parameter int COEFF_W = 16);
  logic valid;
  logic ready;
  logic signed [COEFF_W-1:0] data;
  logic last;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/coeff_bram_writer.sv
// coeff_bram_writer: writes a sign-extended tap stream into BRAM addresses 0..NUM_COEFF-1
// with length checking and vsync hold-off; define COEFF_SUM_EN for a running tap sum output.
module coeff_bram_writer #(
  parameter int NUM_COEFF = 25,
  parameter int COEFF_W = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int GUARD_CYCLES = NUM_COEFF + 2
) (
  input  logic clk,
  input  logic rst_n,
  coeff_bram_writer_if.slave s,
  input  logic vs_i,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic bram_we,
  output logic load_done,
  output logic load_err,
  output logic busy
`ifdef COEFF_SUM_EN
  ,
  output logic signed [COEFF_W+4:0] coeff_sum
`endif
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_COEFF - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state;
  logic vs_dly, vs_fall, acc, write, at_end;
  logic [ADDR_W-1:0] wr_cnt;
  logic [GW-1:0] guard;
  assign vs_fall = vs_dly & ~vs_i;
  assign s.ready = state != DONE && guard == '0 && !vs_fall;
  assign acc = s.valid & s.ready;
  assign at_end = wr_cnt == LAST;
  // a lone s_last tap in IDLE is a zero-length set and is not written
  assign write = acc && (state == LOAD || (state == IDLE && (!s.last || NUM_COEFF == 1)));
  assign busy = state == LOAD || state == DRAIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      vs_dly <= 1'b0;
      guard <= '0;
      wr_cnt <= '0;
      bram_addr <= '0;
      bram_wdata <= '0;
      bram_we <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
`ifdef COEFF_SUM_EN
      coeff_sum <= '0;
`endif
    end else begin
      vs_dly <= vs_i;
      guard <= vs_fall ? GW'(GUARD_CYCLES) : guard - GW'(guard != '0);
      bram_we <= write;
      load_done <= 1'b0;
      if (write) begin
        bram_addr <= wr_cnt;
        bram_wdata <= {{(DATA_W-COEFF_W){s.data[COEFF_W-1]}}, s.data};
`ifdef COEFF_SUM_EN
        coeff_sum <= (state == IDLE ? '0 : coeff_sum) + {{5{s.data[COEFF_W-1]}}, s.data};
`endif
        if (state == IDLE) load_err <= 1'b0;
        wr_cnt <= wr_cnt + 1'b1;
        state <= LOAD;
        if (s.last || at_end) begin
          wr_cnt <= '0;
          state <= s.last ? (at_end ? DONE : IDLE) : DRAIN;
          load_done <= s.last && at_end;
          if (!(s.last && at_end)) load_err <= 1'b1;
        end
      end else if (acc && state == IDLE) begin
        load_err <= 1'b1;
      end else if (acc && state == DRAIN && s.last) begin
        state <= IDLE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_coeff_bram_writer.sv
// tb_coeff_bram_writer: directed tap sets; expected BRAM writes go to a scoreboard queue
// that a negedge monitor checks against every bram_we cycle.
module tb_coeff_bram_writer;
  logic clk = 0, rst_n = 0, vs_i = 1;
  logic [5:0] bram_addr;
  logic [31:0] bram_wdata;
  logic bram_we, load_done, load_err, busy;
`ifdef COEFF_SUM_EN
  logic signed [20:0] coeff_sum;
`endif
  int total = 0, passed = 0;
  typedef struct {logic [5:0] a; logic [31:0] d; logic dn;} wr_t;
  wr_t sb[$];
  wr_t e;
  coeff_bram_writer_if #(.COEFF_W(16)) bus();
  coeff_bram_writer dut (
    .clk(clk), .rst_n(rst_n), .s(bus), .vs_i(vs_i),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
    .load_done(load_done), .load_err(load_err), .busy(busy)
`ifdef COEFF_SUM_EN
    , .coeff_sum(coeff_sum)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic push(input int a, input logic [31:0] d, input logic dn);
    sb.push_back('{a: 6'(a), d: d, dn: dn});
  endtask
  task automatic send(input logic [15:0] d, input logic l);
    int t = 0;
    bus.valid = 1; bus.data = d; bus.last = l;
    while (!bus.ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      total++;
      $display("FAIL send_timeout: ready stayed 0 for %0d cycles, required 1", t);
    end
    @(posedge clk); #1;
    bus.valid = 0; bus.last = 0;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (bram_we) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected", bram_addr, bram_wdata);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(bram_addr), 32'(e.a));
          chk("wr_data", bram_wdata, e.d);
          chk("wr_done", 32'(load_done), 32'(e.dn));
        end
      end else if (load_done) chk("done_without_we", 32'(load_done), 32'd0);
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.valid = 0; bus.data = 0; bus.last = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(bram_we), 0);
    chk("rst_addr", 32'(bram_addr), 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_err", 32'(load_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 25; i++) begin
      push(i, 32'(i + 1), i == 24);
      send(16'(i + 1), i == 24);
      if (i == 12) chk("t1_busy", 32'(busy), 1);
    end
    chk("t1_err", 32'(load_err), 0);
    @(posedge clk); #1;
    chk("t1_idle", 32'(busy), 0);
    for (int i = 0; i < 25; i++) begin
      push(i, 32'(i + 1), i == 24);
      send(16'(i + 1), i == 24);
      if (i == 9) begin
        vs_i = 0;
        #1;
        n = 0;
        while (!bus.ready && n < 100) begin
          n++;
          @(posedge clk); #1;
        end
        chk("t3_holdoff", 32'(n), 28);
        vs_i = 1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      push(i, 32'(i + 1), 0);
      send(16'(i + 1), i == 4);
    end
    chk("t4_err", 32'(load_err), 1);
    chk("t4_busy", 32'(busy), 0);
    push(0, 32'hFFFFFFF0, 0);
    send(16'hFFF0, 0);
    chk("t4_err_clear", 32'(load_err), 0);
    for (int i = 1; i < 25; i++) begin
      push(i, 32'(i + 1), i == 24);
      send(16'(i + 1), i == 24);
    end
    for (int i = 0; i < 30; i++) begin
      if (i < 25) push(i, 32'h100 + 32'(i), 0);
      send(16'h100 + 16'(i), i == 29);
      if (i == 24) chk("t5_err", 32'(load_err), 1);
      if (i == 27) chk("t5_drain_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    chk("t5_idle", 32'(busy), 0);
    chk("t5_err_hold", 32'(load_err), 1);
    for (int i = 0; i < 12; i++) begin
      push(i, 32'(i + 1), 0);
      send(16'(i + 1), 0);
    end
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("t6_we", 32'(bram_we), 0);
    chk("t6_addr", 32'(bram_addr), 0);
    chk("t6_err", 32'(load_err), 0);
    chk("t6_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 25; i++) begin
`ifdef COEFF_SUM_EN
      push(i, 32'hFFFFFFFF, i == 24);
      send(16'hFFFF, i == 24);
`else
      push(i, 32'(i + 1), i == 24);
      send(16'(i + 1), i == 24);
`endif
    end
`ifdef COEFF_SUM_EN
    chk("t6_sum", 32'(coeff_sum), 32'hFFFFFFE7);
`endif
    chk("t6_err_done", 32'(load_err), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
